// File: rtl/sub_bytes_seq_if.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq_if
// Handshake bundle between the round controller, the sequential SubBytes
// engine and the downstream ShiftRows stage.
//   i_valid / i_ready / i_data / i_inverse : block intake (controller -> engine)
//   o_valid / o_ready / o_data             : result delivery (engine -> ShiftRows)
//   busy                                   : engine holds a block (RUN or DONE)
// Modports:
//   slave  - the engine side
//   master - the side that feeds blocks in and drains results
// -----------------------------------------------------------------------------
interface sub_bytes_seq_if;
    logic         i_valid;
    logic         i_ready;
    logic [127:0] i_data;
    logic         i_inverse;
    logic         o_valid;
    logic         o_ready;
    logic [127:0] o_data;
    logic         busy;

    modport slave (
        input  i_valid, i_data, i_inverse, o_ready,
        output i_ready, o_valid, o_data, busy
    );

    modport master (
        output i_valid, i_data, i_inverse, o_ready,
        input  i_ready, o_valid, o_data, busy
    );
endinterface

// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq
// Sequential AES SubBytes engine. A 128-bit state is substituted LANES bytes
// per beat, taking BEATS = 16/LANES beats per block. The forward or inverse
// S-box is selected per block by i_inverse, latched on accept.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset (clears all state, drops any block)
//   bus  - sub_bytes_seq_if.slave: i_valid/i_ready/i_data/i_inverse intake,
//          o_valid/o_ready/o_data result, busy status
// -----------------------------------------------------------------------------
module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            rst,
    sub_bytes_seq_if.slave  bus
);

    localparam int BEATS   = 16 / LANES;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SLICE_W = 8 * LANES;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] s_box_lookup(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_s_box_lookup(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    state_t              state_q;
    logic [127:0]        data_q;
    logic [127:0]        data_d;
    logic                mode_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                o_valid_q;
    logic                busy_q;
    logic                accept;
    logic [6:0]          base;
    logic [SLICE_W-1:0]  slice_in;
    logic [SLICE_W-1:0]  slice_out;

    // Ready in DONE only when the finished block retires on the same edge,
    // which is what lets blocks stream with no bubble.
    assign bus.i_ready = (state_q == IDLE) || ((state_q == DONE) && bus.o_ready);
    assign accept      = bus.i_valid && bus.i_ready;

    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = data_q;
    assign bus.busy    = busy_q;

    // Byte 0 sits at the top of the state, so beat b works downward from bit 127.
    always_comb begin
        base     = 7'(127 - SLICE_W * int'(beat_q));
        slice_in = data_q[base -: SLICE_W];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] b_in;
        logic [7:0] b_fwd;
        logic [7:0] b_inv;
        assign b_in  = slice_in[SLICE_W-1-8*l -: 8];
        assign b_fwd = s_box_lookup(b_in);
        assign b_inv = inv_s_box_lookup(b_in);
        assign slice_out[SLICE_W-1-8*l -: 8] = mode_q ? b_inv : b_fwd;
    end

    always_comb begin
        data_d = data_q;
        data_d[base -: SLICE_W] = slice_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            mode_q    <= 1'b0;
            beat_q    <= '0;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= bus.i_data;
                        mode_q  <= bus.i_inverse;
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    if (beat_q == LAST_BEAT) begin
                        beat_q    <= '0;
                        o_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.o_ready) begin
                        o_valid_q <= 1'b0;
                        if (accept) begin
                            data_q  <= bus.i_data;
                            mode_q  <= bus.i_inverse;
                            beat_q  <= '0;
                            state_q <= RUN;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    o_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_seq
// Bench for sub_bytes_seq. One instance per legal LANES value; the LANES=4
// instance carries the functional scenarios, all five share the sweep.
// The reference S-box is generated with the multiplicative-generator walk
// over GF(2^8), and the inverse table is the permutation inverse of it.
// -----------------------------------------------------------------------------
module tb_sub_bytes_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sub_bytes_seq_if if1 ();
    sub_bytes_seq_if if2 ();
    sub_bytes_seq_if if4 ();
    sub_bytes_seq_if if8 ();
    sub_bytes_seq_if if16 ();

    sub_bytes_seq #(.LANES(1))  u_l1  (.clk(clk), .rst(rst), .bus(if1));
    sub_bytes_seq #(.LANES(2))  u_l2  (.clk(clk), .rst(rst), .bus(if2));
    sub_bytes_seq #(.LANES(4))  u_l4  (.clk(clk), .rst(rst), .bus(if4));
    sub_bytes_seq #(.LANES(8))  u_l8  (.clk(clk), .rst(rst), .bus(if8));
    sub_bytes_seq #(.LANES(16)) u_l16 (.clk(clk), .rst(rst), .bus(if16));

    logic [4:0]   ov_all;
    logic [4:0]   ir_all;
    logic [127:0] od_all [5];
    assign ov_all = {if16.o_valid, if8.o_valid, if4.o_valid, if2.o_valid, if1.o_valid};
    assign ir_all = {if16.i_ready, if8.i_ready, if4.i_ready, if2.i_ready, if1.i_ready};
    assign od_all[0] = if1.o_data;
    assign od_all[1] = if2.o_data;
    assign od_all[2] = if4.o_data;
    assign od_all[3] = if8.o_data;
    assign od_all[4] = if16.o_data;

    int errors;
    int checks;
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv ? isb[d[127-8*i -: 8]] : sb[d[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_all(input logic v, input logic [127:0] d, input logic inv, input logic ordy);
        if1.i_valid = v;  if1.i_data = d;  if1.i_inverse = inv;  if1.o_ready = ordy;
        if2.i_valid = v;  if2.i_data = d;  if2.i_inverse = inv;  if2.o_ready = ordy;
        if4.i_valid = v;  if4.i_data = d;  if4.i_inverse = inv;  if4.o_ready = ordy;
        if8.i_valid = v;  if8.i_data = d;  if8.i_inverse = inv;  if8.o_ready = ordy;
        if16.i_valid = v; if16.i_data = d; if16.i_inverse = inv; if16.o_ready = ordy;
    endtask

    // Offer a block to the LANES=4 engine until it is taken; returns just after the accept edge.
    task automatic start4(input logic [127:0] d, input logic inv);
        int n;
        n = 0;
        if4.i_valid = 1'b1;
        if4.i_data = d;
        if4.i_inverse = inv;
        while (!if4.i_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        if4.i_valid = 1'b0;
    endtask

    // Edges after the accept edge until o_valid; 40 means it never came.
    task automatic wait4(output int n, output bit rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        while (!if4.o_valid && n < 40) begin
            if (if4.i_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if4.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b expected 0", if4.o_valid); end
        checks++; if (if4.i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %b expected 1", if4.i_ready); end
        checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if4.busy); end
        checks++; if (if4.o_data !== 128'h0) begin errors++; $display("FAIL reset_o_data: got %h expected 0", if4.o_data); end
        rst = 1'b0;
    endtask

    task automatic test_forward();
        int n;
        bit rs;
        if4.o_ready = 1'b1;
        start4(128'h00102030405060708090a0b0c0d0e0f0, 1'b0);
        checks++; if (if4.busy !== 1'b1) begin errors++; $display("FAIL fwd_busy: got %b expected 1", if4.busy); end
        wait4(n, rs);
        checks++; if (n + 1 != 5) begin errors++; $display("FAIL fwd_latency: got %0d expected 5", n + 1); end
        checks++; if (if4.o_data !== 128'h63cab7040953d051cd60e0e7ba70e18c) begin errors++; $display("FAIL fwd_data: got %h expected 63cab7040953d051cd60e0e7ba70e18c", if4.o_data); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL fwd_ready_in_run: got %b expected 0", rs); end
        @(posedge clk); #1;
        checks++; if (if4.o_valid !== 1'b0) begin errors++; $display("FAIL fwd_retire_valid: got %b expected 0", if4.o_valid); end
        checks++; if (if4.i_ready !== 1'b1) begin errors++; $display("FAIL fwd_retire_ready: got %b expected 1", if4.i_ready); end
    endtask

    task automatic test_inverse();
        int n;
        bit rs;
        logic [127:0] d;
        logic [127:0] e;
        start4(128'h63cab7040953d051cd60e0e7ba70e18c, 1'b1);
        wait4(n, rs);
        checks++; if (if4.o_data !== 128'h00102030405060708090a0b0c0d0e0f0) begin errors++; $display("FAIL inv_roundtrip: got %h expected 00102030405060708090a0b0c0d0e0f0", if4.o_data); end
        @(posedge clk); #1;
        d = rand128();
        d[127:120] = 8'h63;
        d[7:0] = 8'h16;
        e = model(d, 1'b1);
        start4(d, 1'b1);
        wait4(n, rs);
        checks++; if (if4.o_data[127:120] !== 8'h00) begin errors++; $display("FAIL inv_byte_63: got %h expected 00", if4.o_data[127:120]); end
        checks++; if (if4.o_data[7:0] !== 8'hff) begin errors++; $display("FAIL inv_byte_16: got %h expected ff", if4.o_data[7:0]); end
        checks++; if (if4.o_data !== e) begin errors++; $display("FAIL inv_block: got %h expected %h", if4.o_data, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int n;
        bit rs;
        logic [127:0] d;
        logic inv;
        logic [127:0] e;
        for (int k = 0; k < 12; k++) begin
            d = rand128();
            inv = 1'($urandom_range(0, 1));
            e = model(d, inv);
            start4(d, inv);
            wait4(n, rs);
            checks++; if (n != 4) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 4", k, n); end
            checks++; if (if4.o_data !== e) begin errors++; $display("FAIL rand_data[%0d] inv=%b: got %h expected %h", k, inv, if4.o_data, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sweep();
        int lanes_tab [5] = '{1, 2, 4, 8, 16};
        int lat [5];
        bit got [5];
        bit rs [5];
        logic [127:0] dat [5];
        logic [127:0] e;
        e = model({16{8'h53}}, 1'b0);
        for (int i = 0; i < 5; i++) begin lat[i] = -1; got[i] = 0; rs[i] = 0; dat[i] = '0; end
        set_all(1'b1, {16{8'h53}}, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_all(1'b0, '0, 1'b0, 1'b1);
        for (int n = 0; n <= 25; n++) begin
            for (int i = 0; i < 5; i++) begin
                if (!got[i]) begin
                    if (ov_all[i]) begin
                        got[i] = 1;
                        lat[i] = n;
                        dat[i] = od_all[i];
                    end else if (ir_all[i]) begin
                        rs[i] = 1;
                    end
                end
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (lat[i] + 1 != 16 / lanes_tab[i] + 1) begin errors++; $display("FAIL sweep_latency L=%0d: got %0d expected %0d", lanes_tab[i], lat[i] + 1, 16 / lanes_tab[i] + 1); end
            checks++; if (dat[i] !== e) begin errors++; $display("FAIL sweep_data L=%0d: got %h expected %h", lanes_tab[i], dat[i], e); end
            checks++; if (rs[i] !== 1'b0) begin errors++; $display("FAIL sweep_ready_in_run L=%0d: got %b expected 0", lanes_tab[i], rs[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit rs;
        logic [127:0] d;
        logic [127:0] e;
        d = rand128();
        e = model(d, 1'b0);
        if4.o_ready = 1'b0;
        start4(d, 1'b0);
        wait4(n, rs);
        checks++; if (n != 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", n); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++; if (if4.o_data !== e || if4.o_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %h/%b expected %h/1", c, if4.o_data, if4.o_valid, e); end
            checks++; if (if4.i_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", c, if4.i_ready); end
        end
        if4.i_valid = 1'b1;
        if4.i_data = {16{8'hff}};
        if4.i_inverse = 1'b0;
        #1;
        checks++; if (if4.i_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_blocked: got %b expected 0", if4.i_ready); end
        if4.o_ready = 1'b1;
        #1;
        checks++; if (if4.i_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b expected 1", if4.i_ready); end
        @(posedge clk); #1;
        if4.i_valid = 1'b0;
        checks++; if (if4.o_valid !== 1'b0 || if4.busy !== 1'b1) begin errors++; $display("FAIL bp_same_edge: got valid=%b busy=%b expected valid=0 busy=1", if4.o_valid, if4.busy); end
        wait4(n, rs);
        checks++; if (n != 4) begin errors++; $display("FAIL bp_next_latency: got %0d expected 4", n); end
        checks++; if (if4.o_data !== {16{8'h16}}) begin errors++; $display("FAIL bp_next_data: got %h expected 16..16", if4.o_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_mode_latch();
        int n;
        bit rs;
        logic [127:0] d;
        logic [127:0] e;
        d = rand128();
        e = model(d, 1'b1);
        if4.o_ready = 1'b0;
        start4(d, 1'b1);
        if4.i_inverse = 1'b0;
        if4.i_valid = 1'b1;
        if4.i_data = rand128();
        wait4(n, rs);
        checks++; if (if4.o_data !== e) begin errors++; $display("FAIL mode_latch: got %h expected %h", if4.o_data, e); end
        if4.i_valid = 1'b0;
        if4.o_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit rs;
        logic [127:0] d;
        logic inv;
        logic [127:0] e;
        if4.o_ready = 1'b1;
        start4(rand128(), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (if4.o_valid !== 1'b0) begin errors++; $display("FAIL midrst_o_valid: got %b expected 0", if4.o_valid); end
        checks++; if (if4.i_ready !== 1'b1) begin errors++; $display("FAIL midrst_i_ready: got %b expected 1", if4.i_ready); end
        checks++; if (if4.o_data !== 128'h0) begin errors++; $display("FAIL midrst_o_data: got %h expected 0", if4.o_data); end
        checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", if4.busy); end
        d = rand128();
        inv = 1'($urandom_range(0, 1));
        e = model(d, inv);
        start4(d, inv);
        wait4(n, rs);
        checks++; if (n != 4) begin errors++; $display("FAIL midrst_fresh_latency: got %0d expected 4", n); end
        checks++; if (if4.o_data !== e) begin errors++; $display("FAIL midrst_fresh_data: got %h expected %h", if4.o_data, e); end
        // Reset while parked in DONE discards the finished block.
        if4.o_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (if4.o_valid !== 1'b0 || if4.i_ready !== 1'b1 || if4.o_data !== 128'h0) begin errors++; $display("FAIL donerst: got valid=%b ready=%b data=%h expected 0/1/0", if4.o_valid, if4.i_ready, if4.o_data); end
        if4.o_ready = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        build_tables();
        set_all(1'b0, '0, 1'b0, 1'b1);
        test_reset();
        test_forward();
        test_inverse();
        test_random();
        test_sweep();
        test_backpressure();
        test_mode_latch();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
